// File: rtl/tv80_pkg.sv
// Shared definitions for the tv80 ALU and the 16-bit arithmetic sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package tv80_pkg;

  // ALU_Op encodings understood by the 8-bit ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Bit positions inside the F register
  localparam int FLAG_C = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_P = 2;
  localparam int FLAG_X = 3;
  localparam int FLAG_H = 4;
  localparam int FLAG_Y = 5;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 7;

  // Encoding 2'd3 is reserved and never enters the sequencer
  typedef enum logic [1:0] {
    OP_ADD16 = 2'd0,
    OP_ADC16 = 2'd1,
    OP_SBC16 = 2'd2
  } op16_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  // Low byte of ADD16 starts without carry; ADC/SBC consume the incoming C
  function automatic logic [3:0] lo_alu_op(input op16_t o);
    case (o)
      OP_ADD16: lo_alu_op = ALU_ADD;
      OP_ADC16: lo_alu_op = ALU_ADC;
      default:  lo_alu_op = ALU_SBC;
    endcase
  endfunction

  // High byte always chains the carry out of the low byte
  function automatic logic [3:0] hi_alu_op(input op16_t o);
    hi_alu_op = (o == OP_SBC16) ? ALU_SBC : ALU_ADC;
  endfunction

endpackage

// File: rtl/tv80_alu.sv
// 8-bit tv80 ALU, arithmetic subset (ADD/ADC/SUB/SBC); other opcodes pass F through, Q=0.
// Latency: combinational.
// Backpressure: none.
// Ports: alu_op/arith16/z16 control, busa/busb operands, f_in flags in; q result, f_out flags out.
module tv80_alu
  import tv80_pkg::*;
(
  input  logic [3:0] alu_op,
  input  logic       arith16,
  input  logic       z16,
  input  logic [7:0] busa,
  input  logic [7:0] busb,
  input  logic [7:0] f_in,
  output logic [7:0] q,
  output logic [7:0] f_out
);

  logic       sub;
  logic       use_carry;
  logic       cin;
  logic [7:0] b_eff;
  logic [4:0] h_sum;
  logic [7:0] s7_sum;
  logic [8:0] sum;

  always_comb begin
    sub       = alu_op[1];
    use_carry = ~alu_op[2] & alu_op[0];
    // Subtraction is A + ~B + 1, with borrow-in folded into the carry-in
    cin       = sub ^ (use_carry & f_in[FLAG_C]);
    b_eff     = busb ^ {8{sub}};
    h_sum     = {1'b0, busa[3:0]} + {1'b0, b_eff[3:0]} + {4'b0, cin};
    s7_sum    = {1'b0, busa[6:0]} + {1'b0, b_eff[6:0]} + {7'b0, cin};
    sum       = {1'b0, busa} + {1'b0, b_eff} + {8'b0, cin};

    q     = 8'h00;
    f_out = f_in;
    case (alu_op)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC: begin
        q             = sum[7:0];
        f_out[FLAG_N] = sub;
        // Carry/half-carry are inverted into borrow sense for subtraction
        f_out[FLAG_C] = sum[8] ^ sub;
        f_out[FLAG_H] = h_sum[4] ^ sub;
        f_out[FLAG_P] = s7_sum[7] ^ sum[8];
        f_out[FLAG_X] = sum[3];
        f_out[FLAG_Y] = sum[5];
        f_out[FLAG_S] = sum[7];
        // With Z16 a zero high byte inherits the low-byte Z
        if (sum[7:0] == 8'h00) f_out[FLAG_Z] = z16 ? f_in[FLAG_Z] : 1'b1;
        else                   f_out[FLAG_Z] = 1'b0;
        if (arith16) begin
          f_out[FLAG_S] = f_in[FLAG_S];
          f_out[FLAG_Z] = f_in[FLAG_Z];
          f_out[FLAG_P] = f_in[FLAG_P];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tv80_alu16_seq.sv
// 16-bit ADD/ADC/SBC HL,ss sequenced as low byte then high byte on the 8-bit tv80 ALU.
// Latency: done 3 cycles after start is accepted in IDLE; new op accepted every 4 cycles.
// Backpressure: start is ignored unless IDLE (busy=0); reserved op=3 is dropped.
// Ports: clk/reset; start/op/opa/opb/f_in request; busy/done/result/f_out status;
//        alu_op/alu_arith16/alu_z16/alu_busa/alu_busb/alu_f_in drive the ALU, alu_q/alu_f_out return.
module tv80_alu16_seq
  import tv80_pkg::*;
#(
  parameter int Flag_C = 0,
  parameter int Flag_H = 4,
  parameter int Flag_Z = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [7:0]  f_out,
  output logic [3:0]  alu_op,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out
);

  state_t     state;
  op16_t      op_r;
  logic [7:0] opa_hi;
  logic [7:0] opb_hi;
  logic [7:0] lo_q;
  logic [7:0] lo_f;

  // ALU drive registers are loaded with the values for the state being entered,
  // so the ALU sees them for the whole of that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= 16'h0000;
      f_out       <= 8'h00;
      op_r        <= OP_ADD16;
      opa_hi      <= 8'h00;
      opb_hi      <= 8'h00;
      lo_q        <= 8'h00;
      lo_f        <= 8'h00;
      alu_op      <= ALU_NOP;
      alu_arith16 <= 1'b0;
      alu_z16     <= 1'b0;
      alu_busa    <= 8'h00;
      alu_busb    <= 8'h00;
      alu_f_in    <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (op != 2'd3)) begin
            state       <= S_LO;
            busy        <= 1'b1;
            op_r        <= op16_t'(op);
            opa_hi      <= opa[15:8];
            opb_hi      <= opb[15:8];
            alu_op      <= lo_alu_op(op16_t'(op));
            alu_arith16 <= (op == OP_ADD16);
            alu_z16     <= 1'b0;
            alu_busa    <= opa[7:0];
            alu_busb    <= opb[7:0];
            alu_f_in    <= f_in;
          end
        end
        S_LO: begin
          state       <= S_HI;
          lo_q        <= alu_q;
          lo_f        <= alu_f_out;
          alu_op      <= hi_alu_op(op_r);
          alu_arith16 <= (op_r == OP_ADD16);
          // Z16 lets a zero high byte keep the low byte's Z verdict
          alu_z16     <= (op_r != OP_ADD16);
          alu_busa    <= opa_hi;
          alu_busb    <= opb_hi;
          alu_f_in    <= alu_f_out;
        end
        S_HI: begin
          state       <= S_FIN;
          result      <= {alu_q, lo_q};
          f_out       <= alu_f_out;
          done        <= 1'b1;
          alu_op      <= ALU_NOP;
          alu_arith16 <= 1'b0;
          alu_z16     <= 1'b0;
          alu_busa    <= 8'h00;
          alu_busb    <= 8'h00;
          alu_f_in    <= alu_f_out;
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The high-byte step must see the low-byte carry, half-carry and Z unchanged
  hi_chain_a : assert property (@(posedge clk) disable iff (reset)
    (state == S_HI) |-> (alu_f_in[Flag_C] == lo_f[Flag_C] &&
                         alu_f_in[Flag_H] == lo_f[Flag_H] &&
                         alu_f_in[Flag_Z] == lo_f[Flag_Z]));

endmodule
